adc_spi_responder: RTL and testbench

//  Behavioural-synthesizable responder for the 4-wire ADC link (CONVST/SCK/MOSI/MISO): the ADC end of the

---
 rtl/adc_spi_responder.sv | 200 ++++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// ADC end of the 4-wire CONVST/SCK/MOSI/MISO link.
// A CONVST rise latches i_sample and starts a modelled conversion. The result
// is then shifted out MSB-first on MISO, one bit per SCK fall, while the
// config word is captured from MOSI on the first CFG_BITS SCK rises.
// All link pins are asynchronous, so they are synchronized into i_clk first.
module adc_spi_responder #(
  parameter int DATA_BITS   = 12,
  parameter int CFG_BITS    = 6,
  parameter int CONV_CYCLES = 80
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_sample,
  input  logic                 i_convst,
  input  logic                 i_sck,
  input  logic                 i_mosi,
  output logic                 o_miso,
  output logic                 o_busy,
  output logic [CFG_BITS-1:0]  o_cfg_word,
  output logic                 o_cfg_valid,
  output logic                 o_frame_err
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] CFG_LAST  = BIT_W'(CFG_BITS - 1);
  localparam logic [BIT_W-1:0] CFG_COUNT = BIT_W'(CFG_BITS);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READY,
    SHIFT
  } state_t;

  // Synchronizer pipes: [0] first flop, [1] synced level, [2] delayed copy for edges.
  logic [2:0] convst_pipe;
  logic [2:0] sck_pipe;
  logic [1:0] mosi_pipe;

  logic convst_lvl, convst_rise, sck_rise, sck_fall, mosi_bit;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   result_q, result_d;
  logic [CNT_W-1:0]       conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CFG_BITS-1:0]    cfg_shift_q, cfg_shift_d;
  logic [CFG_BITS-1:0]    cfg_word_q, cfg_word_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic [CFG_BITS-1:0]    cfg_shift_in;
  logic [DATA_BITS-1:0]   result_shl;

  // Two-flop synchronizers plus one extra stage per edge-detected pin.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      convst_pipe <= '0;
      sck_pipe    <= '0;
      mosi_pipe   <= '0;
    end else begin
      convst_pipe <= {convst_pipe[1:0], i_convst};
      sck_pipe    <= {sck_pipe[1:0], i_sck};
      mosi_pipe   <= {mosi_pipe[0], i_mosi};
    end
  end

  assign convst_lvl  = convst_pipe[1];
  assign convst_rise = convst_pipe[1] & ~convst_pipe[2];
  assign sck_rise    = sck_pipe[1] & ~sck_pipe[2];
  assign sck_fall    = ~sck_pipe[1] & sck_pipe[2];
  assign mosi_bit    = mosi_pipe[1];

  assign cfg_shift_in = (cfg_shift_q << 1) | CFG_BITS'(mosi_bit);
  assign result_shl   = result_q << 1;

  // State and datapath registers; everything returns to idle on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      conv_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      cfg_shift_q <= '0;
      cfg_word_q  <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      conv_cnt_q  <= conv_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_word_q  <= cfg_word_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      cfg_valid_q <= cfg_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state and datapath update; a CONVST rise always takes priority over SCK.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    result_d    = result_q;
    conv_cnt_d  = conv_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    cfg_shift_d = cfg_shift_q;
    cfg_word_d  = cfg_word_q;
    miso_d      = miso_q;
    busy_d      = busy_q;
    cfg_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (convst_rise) begin
          result_d   = i_sample;
          conv_cnt_d = CONV_LOAD;
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end
      end

      CONVERT: begin
        // A second CONVST mid-conversion is flagged but does not restart it.
        if (convst_rise) begin
          frame_err_d = 1'b1;
        end
        if (conv_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = READY;
        end else begin
          conv_cnt_d = conv_cnt_q - 1'b1;
        end
      end

      READY: begin
        if (convst_rise) begin
          // Skipping the read-out is legal: just start the next conversion.
          result_d   = i_sample;
          conv_cnt_d = CONV_LOAD;
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end else if (!convst_lvl) begin
          miso_d    = result_q[DATA_BITS-1];
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (convst_rise) begin
          // Truncated frame: report it and start the new conversion.
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          result_d    = i_sample;
          conv_cnt_d  = CONV_LOAD;
          busy_d      = 1'b1;
          state_d     = CONVERT;
        end else if (sck_rise) begin
          if (bit_cnt_q < CFG_COUNT) begin
            cfg_shift_d = cfg_shift_in;
            if (bit_cnt_q == CFG_LAST) begin
              cfg_word_d  = cfg_shift_in;
              cfg_valid_d = 1'b1;
            end
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (sck_fall) begin
          if (bit_cnt_q == DATA_LAST) begin
            miso_d  = 1'b0;
            state_d = IDLE;
          end else begin
            result_d = result_shl;
            miso_d   = result_shl[DATA_BITS-1];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_miso      = miso_q;
  assign o_busy      = busy_q;
  assign o_cfg_word  = cfg_word_q;
  assign o_cfg_valid = cfg_valid_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: one instance with default timing,
// one with CONV_CYCLES=1 driven from the same link pins for the fast-timing case.
module tb_adc_spi_responder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [11:0] i_sample = '0;
  logic        i_convst = 1'b0;
  logic        i_sck = 1'b0;
  logic        i_mosi = 1'b0;

  logic        o_miso, o_busy, o_cfg_valid, o_frame_err;
  logic [5:0]  o_cfg_word;
  logic        miso1, busy1, cfg_valid1, frame_err1;
  logic [5:0]  cfg_word1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int busy_seen = 0;
  int valid_seen = 0;
  int err_seen = 0;
  int busy1_seen = 0;
  int valid1_seen = 0;

  adc_spi_responder dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sample   (i_sample),
    .i_convst   (i_convst),
    .i_sck      (i_sck),
    .i_mosi     (i_mosi),
    .o_miso     (o_miso),
    .o_busy     (o_busy),
    .o_cfg_word (o_cfg_word),
    .o_cfg_valid(o_cfg_valid),
    .o_frame_err(o_frame_err)
  );

  adc_spi_responder #(.CONV_CYCLES(1)) dut_fast (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sample   (i_sample),
    .i_convst   (i_convst),
    .i_sck      (i_sck),
    .i_mosi     (i_mosi),
    .o_miso     (miso1),
    .o_busy     (busy1),
    .o_cfg_word (cfg_word1),
    .o_cfg_valid(cfg_valid1),
    .o_frame_err(frame_err1)
  );

  always #5 i_clk = ~i_clk;

  // Pulse/level counters sampled on the inactive edge.
  always @(negedge i_clk) begin
    if (o_busy)      busy_seen   <= busy_seen + 1;
    if (o_cfg_valid) valid_seen  <= valid_seen + 1;
    if (o_frame_err) err_seen    <= err_seen + 1;
    if (busy1)       busy1_seen  <= busy1_seen + 1;
    if (cfg_valid1)  valid1_seen <= valid1_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // CONVST pulse with optional SCK toggling during conversion; waits (bounded)
  // for busy to drop and for the responder to reach its shift state.
  task automatic start_conv(input logic [11:0] s, input int toggles, output int busy_cycles);
    int b0;
    int guard;
    b0 = busy_seen;
    i_sample = s;
    i_convst = 1'b1;
    tick(4);
    i_convst = 1'b0;
    for (int t = 0; t < toggles; t++) begin
      i_sck = 1'b1;
      tick(4);
      i_sck = 1'b0;
      tick(4);
    end
    guard = 0;
    while (o_busy && guard < 300) begin
      tick(1);
      guard++;
    end
    check("conv_wait_bound", 32'(guard < 300), 32'd1);
    tick(5);
    busy_cycles = busy_seen - b0;
  endtask

  // Drives nrise SCK periods; MISO is read just before each rising edge.
  task automatic run_frame(input bit sel, input logic [5:0] cfg, input int half,
                           input int nrise, output logic [11:0] rd);
    rd = '0;
    for (int k = 0; k < nrise; k++) begin
      rd[11-k] = sel ? miso1 : o_miso;
      i_mosi = (k < 6) ? cfg[5-k] : 1'b0;
      i_sck = 1'b1;
      tick(half);
      i_sck = 1'b0;
      tick(half);
    end
  endtask

  initial begin
    int busy_cycles;
    int v0;
    int e0;
    logic [11:0] rd;

    // 1: reset state and a basic frame
    tick(3);
    i_rst = 1'b0;
    tick(1);
    check("rst_miso", 32'(o_miso), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_cfg_word", 32'(o_cfg_word), 32'd0);
    check("rst_cfg_valid", 32'(o_cfg_valid), 32'd0);
    check("rst_frame_err", 32'(o_frame_err), 32'd0);

    v0 = valid_seen;
    e0 = err_seen;
    start_conv(12'hAB3, 0, busy_cycles);
    check("t1_busy_cycles", 32'(busy_cycles), 32'd80);
    run_frame(1'b0, 6'b100000, 4, 12, rd);
    tick(2);
    check("t1_miso_data", 32'(rd), 32'hAB3);
    check("t1_cfg_word", 32'(o_cfg_word), 32'h20);
    check("t1_cfg_valid_cnt", 32'(valid_seen - v0), 32'd1);
    check("t1_idle_miso", 32'(o_miso), 32'd0);
    check("t1_no_err", 32'(err_seen - e0), 32'd0);

    // 2: back-to-back frames with all-zero and all-one samples
    start_conv(12'h000, 0, busy_cycles);
    check("t2a_busy_cycles", 32'(busy_cycles), 32'd80);
    run_frame(1'b0, 6'h15, 4, 12, rd);
    tick(2);
    check("t2a_miso_data", 32'(rd), 32'h000);
    check("t2a_cfg_word", 32'(o_cfg_word), 32'h15);
    check("t2a_idle_miso", 32'(o_miso), 32'd0);
    start_conv(12'hFFF, 0, busy_cycles);
    run_frame(1'b0, 6'h2A, 4, 12, rd);
    tick(2);
    check("t2b_miso_data", 32'(rd), 32'hFFF);
    check("t2b_cfg_word", 32'(o_cfg_word), 32'h2A);
    check("t2b_idle_miso", 32'(o_miso), 32'd0);

    // 3: SCK activity during conversion is ignored
    e0 = err_seen;
    start_conv(12'hA5A, 5, busy_cycles);
    check("t3_busy_cycles", 32'(busy_cycles), 32'd80);
    check("t3_frame_start_msb", 32'(o_miso), 32'd1);
    check("t3_no_err", 32'(err_seen - e0), 32'd0);
    run_frame(1'b0, 6'h0F, 4, 12, rd);
    tick(2);
    check("t3_miso_data", 32'(rd), 32'hA5A);
    check("t3_cfg_word", 32'(o_cfg_word), 32'h0F);

    // 4: frame truncated by CONVST after 4 SCK rises
    start_conv(12'h3C5, 0, busy_cycles);
    v0 = valid_seen;
    e0 = err_seen;
    run_frame(1'b0, 6'h33, 4, 4, rd);
    check("t4_partial_data", 32'(rd), 32'h300);
    start_conv(12'h7E1, 0, busy_cycles);
    check("t4_busy_cycles", 32'(busy_cycles), 32'd80);
    check("t4_err_cnt", 32'(err_seen - e0), 32'd1);
    check("t4_cfg_unchanged", 32'(o_cfg_word), 32'h0F);
    check("t4_no_cfg_valid", 32'(valid_seen - v0), 32'd0);
    run_frame(1'b0, 6'h12, 4, 12, rd);
    tick(2);
    check("t4_miso_data", 32'(rd), 32'h7E1);
    check("t4_cfg_word", 32'(o_cfg_word), 32'h12);

    // 5: synchronous reset after 7 SCK falls
    start_conv(12'h9D2, 0, busy_cycles);
    e0 = err_seen;
    run_frame(1'b0, 6'h3F, 4, 7, rd);
    check("t5_partial_data", 32'(rd), 32'h9C0);
    i_rst = 1'b1;
    tick(1);
    check("t5_rst_miso", 32'(o_miso), 32'd0);
    check("t5_rst_busy", 32'(o_busy), 32'd0);
    check("t5_rst_cfg_word", 32'(o_cfg_word), 32'd0);
    check("t5_rst_cfg_valid", 32'(o_cfg_valid), 32'd0);
    check("t5_rst_frame_err", 32'(o_frame_err), 32'd0);
    i_rst = 1'b0;
    tick(2);
    check("t5_no_err", 32'(err_seen - e0), 32'd0);
    start_conv(12'h4E7, 0, busy_cycles);
    check("t5_busy_cycles", 32'(busy_cycles), 32'd80);
    run_frame(1'b0, 6'h0B, 4, 12, rd);
    tick(2);
    check("t5_miso_data", 32'(rd), 32'h4E7);
    check("t5_cfg_word", 32'(o_cfg_word), 32'h0B);

    // 6: one-cycle conversion and minimum SCK phases on the fast instance
    e0 = busy1_seen;
    v0 = valid1_seen;
    i_sample = 12'h6C9;
    i_convst = 1'b1;
    tick(4);
    i_convst = 1'b0;
    tick(8);
    check("t6_busy_cycles", 32'(busy1_seen - e0), 32'd1);
    run_frame(1'b1, 6'h2D, 3, 12, rd);
    tick(2);
    check("t6_miso_data", 32'(rd), 32'h6C9);
    check("t6_cfg_word", 32'(cfg_word1), 32'h2D);
    check("t6_cfg_valid_cnt", 32'(valid1_seen - v0), 32'd1);
    check("t6_idle_miso", 32'(miso1), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
